// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown control stage: FSM encodings,
// preset limits and the default debounce length.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_SETUP   = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  localparam int MAX_SEC             = 9;
  localparam int DEBOUNCE_CYCLES_DEF = 250000;

  // Next preset value, wrapping MAX_SEC back to 0 so the value stays BCD-safe.
  function automatic logic [3:0] next_preset(input logic [3:0] cur);
    if (cur >= 4'(MAX_SEC)) begin
      return 4'd0;
    end
    return cur + 4'd1;
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Link between the control stage and the countdown Timer.
interface countdown_ctrl_if;

  logic [3:0] cur_sec;
  logic       zero;
  logic       set;
  logic [3:0] new_sec;

  // Control side: drives load/preset, watches the countdown.
  modport master (
    output set,
    output new_sec,
    input  cur_sec,
    input  zero
  );

  // Timer side.
  modport slave (
    input  set,
    input  new_sec,
    output cur_sec,
    output zero
  );

endinterface

// File: rtl/countdown_ctrl_btn_debounce.sv
// One pushbutton: 2-FF synchronizer, stability counter, and a registered
// rising-edge detector producing a single press pulse per accepted press.
module btn_debounce
  import countdown_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and one-cycle press pulse on an accepted 0->1 change.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown control: debounced buttons, 0-9 s preset, Timer load control and
// a registered one-cycle timeout pulse on countdown expiry.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DEFAULT_SEC     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_up,
  input  logic             btn_stop,
  countdown_ctrl_if.master tmr,
  output logic             running,
  output logic             timeout,
  output logic [1:0]       state
);

  logic   start_p, up_p, stop_p;
  state_e state_q, state_d;
  logic [3:0] preset_q, preset_d;
  logic   timeout_q, timeout_d;
  logic   expiry;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .btn_raw(btn_start), .press(start_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_raw(btn_up), .press(up_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
    .clk(clk), .rst(rst), .btn_raw(btn_stop), .press(stop_p)
  );

  // Timer reached its terminal tick at second 0.
  assign expiry = tmr.zero && (tmr.cur_sec == 4'd0);

  // Next state, preset and timeout; expiry outranks stop, start outranks up.
  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_SETUP: begin
        if (start_p) begin
          state_d = ST_RUN;
        end else if (up_p) begin
          preset_d = next_preset(preset_q);
        end
      end
      ST_RUN: begin
        if (expiry) begin
          state_d   = ST_EXPIRED;
          timeout_d = 1'b1;
        end else if (stop_p) begin
          state_d = ST_SETUP;
        end
      end
      ST_EXPIRED: begin
        if (start_p || stop_p) begin
          state_d = ST_SETUP;
        end
      end
      default: begin
        state_d = ST_SETUP;
      end
    endcase
  end

  // State, preset and timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SETUP;
      preset_q  <= 4'(DEFAULT_SEC);
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decoded straight from registers.
  assign tmr.set     = (state_q == ST_SETUP);
  assign tmr.new_sec = preset_q;
  assign running     = (state_q == ST_RUN);
  assign timeout     = timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a small behavioural Timer model.
module tb_countdown_ctrl;
  import countdown_pkg::*;

  localparam int DB   = 4;
  localparam int TICK = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_start = 1'b0, btn_up = 1'b0, btn_stop = 1'b0;
  logic running, timeout;
  logic [1:0] state;

  // Timer model, or manual override for exact-cycle scenarios
  logic [3:0] m_sec;
  logic [3:0] m_div;
  logic       manual = 1'b0;
  logic [3:0] man_sec = 4'd0;
  logic       man_zero = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  countdown_ctrl_if tif ();

  countdown_ctrl #(.DEBOUNCE_CYCLES(DB), .DEFAULT_SEC(9)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_up(btn_up), .btn_stop(btn_stop),
    .tmr(tif.master),
    .running(running), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tif.set) begin
      m_sec <= tif.new_sec;
      m_div <= 4'd0;
    end else if (m_div == 4'(TICK - 1)) begin
      m_div <= 4'd0;
      if (m_sec != 4'd0) m_sec <= m_sec - 4'd1;
    end else begin
      m_div <= m_div + 4'd1;
    end
  end

  assign tif.cur_sec = manual ? man_sec : m_sec;
  assign tif.zero    = manual ? man_zero :
                       (!tif.set && m_div == 4'(TICK - 1) && m_sec == 4'd0);

  task automatic press_btn(input logic s, input logic u, input logic p);
    @(negedge clk);
    btn_start = s; btn_up = u; btn_stop = p;
    repeat (9) @(posedge clk);
    @(negedge clk);
    btn_start = 1'b0; btn_up = 1'b0; btn_stop = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_checks++; if (tif.set !== 1'b1) begin n_fail++; $display("FAIL reset_set got %b want 1", tif.set); end
    n_checks++; if (tif.new_sec !== 4'd9) begin n_fail++; $display("FAIL reset_new_sec got %0d want 9", tif.new_sec); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
    $display("reset: set=%b new_sec=%0d state=%0d", tif.set, tif.new_sec, state);
  endtask

  task automatic test_hold_up;
    @(negedge clk); btn_up = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk); btn_up = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if (tif.new_sec !== 4'd0) begin n_fail++; $display("FAIL hold_up_wrap got %0d want 0", tif.new_sec); end
    $display("hold up 50 cycles: new_sec=%0d", tif.new_sec);
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); btn_up = ~i[0];
      @(negedge clk);
    end
    btn_up = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk); btn_up = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if (tif.new_sec !== 4'd1) begin n_fail++; $display("FAIL bounce_one_inc got %0d want 1", tif.new_sec); end
    $display("bounce then hold: new_sec=%0d", tif.new_sec);
    press_btn(1'b0, 1'b1, 1'b0);
    press_btn(1'b0, 1'b1, 1'b0);
    n_checks++; if (tif.new_sec !== 4'd3) begin n_fail++; $display("FAIL up_to_3 got %0d want 3", tif.new_sec); end
    for (int i = 0; i < 10; i++) press_btn(1'b0, 1'b1, 1'b0);
    n_checks++; if (tif.new_sec !== 4'd3) begin n_fail++; $display("FAIL ten_presses got %0d want 3", tif.new_sec); end
    $display("ten presses from 3: new_sec=%0d", tif.new_sec);
  endtask

  task automatic test_run_expire;
    int seen;
    for (int i = 0; i < 9; i++) press_btn(1'b0, 1'b1, 1'b0);
    n_checks++; if (tif.new_sec !== 4'd2) begin n_fail++; $display("FAIL preset_2 got %0d want 2", tif.new_sec); end
    press_btn(1'b1, 1'b0, 1'b0);
    n_checks++; if (tif.set !== 1'b0) begin n_fail++; $display("FAIL run_set got %b want 0", tif.set); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_running got %b want 1", running); end
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL run_state got %0d want 1", state); end
    seen = 0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) seen = 1;
    end
    n_checks++; if (seen != 1) begin n_fail++; $display("FAIL timeout_seen got %0d want 1", seen); end
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL expired_state got %0d want 2", state); end
    @(negedge clk);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_one_cycle got %b want 0", timeout); end
    $display("expiry: timeout seen=%0d state=%0d", seen, state);
    press_btn(1'b0, 1'b1, 1'b0);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL up_ignored_expired got %0d want 2", state); end
    press_btn(1'b0, 1'b0, 1'b1);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL stop_from_expired got %0d want 0", state); end
  endtask

  task automatic test_stop;
    int hit;
    for (int i = 0; i < 5; i++) press_btn(1'b0, 1'b1, 1'b0);
    n_checks++; if (tif.new_sec !== 4'd7) begin n_fail++; $display("FAIL preset_7 got %0d want 7", tif.new_sec); end
    press_btn(1'b1, 1'b0, 1'b0);
    press_btn(1'b0, 1'b1, 1'b0);
    n_checks++; if (tif.new_sec !== 4'd7) begin n_fail++; $display("FAIL up_ignored_run got %0d want 7", tif.new_sec); end
    hit = 0;
    for (int i = 0; i < 200 && hit == 0; i++) begin
      @(negedge clk);
      if (m_sec <= 4'd5) hit = 1;
    end
    n_checks++; if (hit != 1) begin n_fail++; $display("FAIL reach_sec5 got %0d want 1", hit); end
    press_btn(1'b0, 1'b0, 1'b1);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL stop_state got %0d want 0", state); end
    n_checks++; if (tif.set !== 1'b1) begin n_fail++; $display("FAIL stop_set got %b want 1", tif.set); end
    n_checks++; if (tif.new_sec !== 4'd7) begin n_fail++; $display("FAIL stop_preset got %0d want 7", tif.new_sec); end
    $display("stop in run: state=%0d new_sec=%0d", state, tif.new_sec);
  endtask

  task automatic test_coincident;
    manual = 1'b1; man_sec = 4'd3; man_zero = 1'b0;
    press_btn(1'b1, 1'b0, 1'b0);
    // stop raw edge just before E1; its press pulse sits between E7 and E8
    btn_stop = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk); man_sec = 4'd0; man_zero = 1'b1;
    @(negedge clk); man_zero = 1'b0; man_sec = 4'd3;
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL coinc_timeout got %b want 1", timeout); end
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL coinc_state got %0d want 2", state); end
    $display("stop+expiry same cycle: timeout=%b state=%0d", timeout, state);
    btn_stop = 1'b0;
    repeat (10) @(posedge clk);
    press_btn(1'b1, 1'b0, 1'b0);
    press_btn(1'b1, 1'b1, 1'b0);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_up_state got %0d want 1", state); end
    n_checks++; if (tif.new_sec !== 4'd7) begin n_fail++; $display("FAIL start_up_preset got %0d want 7", tif.new_sec); end
    $display("start+up in setup: state=%0d new_sec=%0d", state, tif.new_sec);
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rstrun_state got %0d want 0", state); end
    n_checks++; if (tif.set !== 1'b1) begin n_fail++; $display("FAIL rstrun_set got %b want 1", tif.set); end
    n_checks++; if (tif.new_sec !== 4'd9) begin n_fail++; $display("FAIL rstrun_new_sec got %0d want 9", tif.new_sec); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rstrun_timeout got %b want 0", timeout); end
    $display("reset mid-run: state=%0d set=%b new_sec=%0d", state, tif.set, tif.new_sec);
  endtask

  task automatic test_illegal;
    press_btn(1'b1, 1'b0, 1'b0);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL illegal_pre_run got %0d want 1", state); end
    @(negedge clk);
    force dut.state_q = state_e'(2'd3);
    #1 release dut.state_q;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL illegal_recover got %0d want 0", state); end
    n_checks++; if (tif.set !== 1'b1) begin n_fail++; $display("FAIL illegal_set got %b want 1", tif.set); end
    $display("illegal state recovery: state=%0d", state);
  endtask

  initial begin
    test_reset();
    test_hold_up();
    test_bounce();
    test_run_expire();
    test_stop();
    test_coincident();
    test_reset_mid_run();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Control stage directly upstream of the countdown Timer. Debounces three raw pushbuttons (start, up, stop), lets the user dial a 0–9 s preset, and drives the Timer's `set`/`new_sec` inputs. Watches the Timer's `cur_sec`/`zero` outputs and raises a one-cycle `timeout` pulse when the countdown expires. The pulse feeds the AES encrypter's session-abort logic.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: cycles a synchronized button must be stable before it is accepted (10 ms at 25 MHz).
- `DEFAULT_SEC`, default 9: preset loaded at reset (0–9).

- `clk`  in  1  25 MHz clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `btn_start`  in  1  raw pushbutton, asynchronous, active-high
- `btn_up`  in  1  raw pushbutton: increment preset
- `btn_stop`  in  1  raw pushbutton: abort/return to setup
- `cur_sec`  in  4  Timer's current second
- `zero`  in  1  Timer's one-cycle 1 Hz terminal tick
- `set`  out  1  to Timer: 1 = load/hold `new_sec`
- `new_sec`  out  4  to Timer: preset value, 0–9
- `running`  out  1  high in RUN
- `timeout`  out  1  one-cycle expiry pulse
- `state`  out  2  current FSM state (debug/LED)

## Operation
- Each button: 2-FF synchronizer, then stability counter. The accepted level changes only after `DEBOUNCE_CYCLES` consecutive identical synchronized samples. A 0→1 change of the accepted level emits a one-cycle press pulse. Holding a button gives exactly one pulse.
- FSM states: SETUP=0, RUN=1, EXPIRED=2. Encoding 3 is illegal and recovers to SETUP on the next edge.
- SETUP: `set`=1.
  - Up pulse: `new_sec` ← `new_sec`+1, wrapping 9→0.
  - Start pulse: go to RUN.
  - Start and up in the same cycle: start wins and the preset is unchanged.
- RUN: `set`=0, `running`=1.
  - Expiry: `zero`=1 while `cur_sec`=0. Go to EXPIRED and pulse `timeout`.
  - Stop pulse: go to SETUP. The preset is retained, so the Timer reloads it.
  - Expiry and stop in the same cycle: expiry wins (`timeout` pulses, go to EXPIRED).
  - Up pulses are ignored.
- EXPIRED: `set`=0, so the Timer holds 0.
  - Start or stop pulse: go to SETUP.
  - Up is ignored.
- `new_sec` changes only in SETUP. Arithmetic is 4-bit and never exceeds 9.
- Reset values:
  - state=SETUP, `set`=1, `new_sec`=`DEFAULT_SEC`, `running`=0, `timeout`=0.
  - Debounce accepted levels=0 and counters=0.
- Reset mid-RUN aborts the countdown. `set`=1 on the first post-reset cycle forces the Timer to reload.

## Timing
- Button latency: raw edge to press pulse = 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- State and all state-decoded outputs (`set`, `running`, `state`) change on the edge after the press-pulse cycle.
- `timeout` is registered. It is high for exactly the one cycle after the qualifying `zero` cycle, coincident with state=EXPIRED.
- `new_sec` updates on the edge after an up pulse. It is stable whenever `set`=1 is sampled by the Timer, except in that update cycle.
- The Timer never emits `zero` while `set`=1, so SETUP needs no `zero` handling.
- All outputs are registered or decoded directly from registers. There are no combinational paths from inputs to outputs.

## Structure
- `countdown_pkg`:
  - state encodings (SETUP/RUN/EXPIRED)
  - `MAX_SEC`=9
  - default `DEBOUNCE_CYCLES`
- Sub-module `btn_debounce` (param `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `btn_raw`, `press`). It contains the synchronizer, stability counter and edge detector, and is instantiated three times.
- Top level holds the FSM, the preset register and the `timeout` register.

## Test plan
(Benches use `DEBOUNCE_CYCLES`=4 and drive `cur_sec`/`zero` from a behavioural Timer model.)
- Reset then idle: `set`=1, `new_sec`=9, state=0, `running`=0, `timeout`=0. Hold `btn_up` 50 cycles → exactly one increment, `new_sec`=0 (wrap).
- Bounce `btn_up` with 0/1 toggles every 2 cycles for 40 cycles, then hold 1 → exactly one increment. Ten further clean presses from 3 → `new_sec`=3.
- Press start with preset 2 → `set`=0, `running`=1. Model counts 2,1,0. `zero` with `cur_sec`=0 → `timeout` high 1 cycle, state=2.
- In RUN, press stop at `cur_sec`=5 → state=0, `set`=1, `new_sec` still 7 (preset).
- Stop press pulse coincident with a qualifying `zero`/`cur_sec`=0 → `timeout`=1, state=2. Start and up pulses together in SETUP → RUN, `new_sec` unchanged.
- Assert `rst` for 1 cycle mid-RUN → next cycle state=0, `set`=1, `new_sec`=9, `timeout`=0. Force state=3 → SETUP next edge.
